// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm
//   Multicycle sequencer for the 16-bit datapath. Fetches one instruction at a
//   time over a req/ack port and owns the 16-entry register file. It drives the
//   ALU operands and select, and steps or loads the external PC. It sits next to
//   the alu and pc blocks, and together they form an executing processor.
//
// Ports
//   clk, rstn          clock (rising edge), synchronous active-low reset
//   start              leave IDLE/HALT and fetch at the current pc_counter
//   imem_req/addr      fetch request and address (address = pc_counter while req)
//   imem_ack/data      fetch data valid strobe and instruction word
//   alu_data_1/2       ALU operands A/B, updated only on DECODE->EXEC of ALU ops
//   alu_sel            ALU operation select (= opcode for ops 0x0-0x7)
//   alu_out/zero_flag  combinational ALU result and its zero flag
//   pc_counter         current PC
//   pc_data/load/inc   PC load value, 1-cycle load pulse, 1-cycle increment pulse
//   busy               high in every state except IDLE and HALT
//   halted             high in HALT
//   zero_flag          ALU zero flag registered by the last ALU instruction
//
// State table
//   state    | meaning
//   S_IDLE   | after reset, waiting for start
//   S_FETCH  | imem_req high, waiting for imem_ack
//   S_DECODE | instruction latched, register operands read
//   S_EXEC   | ALU operands stable, result/branch resolved, rd written at exit
//   S_WB     | pc_inc or pc_load pulse presented
//   S_HALT   | HALT executed, waiting for start (PC untouched)

module mips_ctrl_fsm #(
    parameter int WORD_SIZE = 16,
    parameter int OP_SIZE   = 4,
    parameter int NUM_REGS  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_data,
    output logic [WORD_SIZE-1:0] alu_data_1,
    output logic [WORD_SIZE-1:0] alu_data_2,
    output logic [OP_SIZE-1:0]   alu_sel,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_zero_flag,
    input  logic [WORD_SIZE-1:0] pc_counter,
    output logic [WORD_SIZE-1:0] pc_data,
    output logic                 pc_load,
    output logic                 pc_inc,
    output logic                 busy,
    output logic                 halted,
    output logic                 zero_flag
);

    localparam int RIDX_W = $clog2(NUM_REGS);

    localparam logic [OP_SIZE-1:0] OP_LI   = OP_SIZE'(8);
    localparam logic [OP_SIZE-1:0] OP_BEQZ = OP_SIZE'(9);
    localparam logic [OP_SIZE-1:0] OP_JMP  = OP_SIZE'(10);
    localparam logic [OP_SIZE-1:0] OP_HALT = OP_SIZE'(15);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] instr_q;
    logic [WORD_SIZE-1:0] rd_val_q;
    logic [WORD_SIZE-1:0] rf_q [NUM_REGS];

    logic                 imem_req_q;
    logic [WORD_SIZE-1:0] alu_data_1_q;
    logic [WORD_SIZE-1:0] alu_data_2_q;
    logic [OP_SIZE-1:0]   alu_sel_q;
    logic [WORD_SIZE-1:0] pc_data_q;
    logic                 pc_load_q;
    logic                 pc_inc_q;
    logic                 busy_q;
    logic                 halted_q;
    logic                 zero_flag_q;

    // Instruction fields, valid from DECODE onwards
    logic [OP_SIZE-1:0]   op_w;
    logic [RIDX_W-1:0]    rd_idx;
    logic [RIDX_W-1:0]    rs_idx;
    logic [RIDX_W-1:0]    rt_idx;
    logic                 is_alu;
    logic [WORD_SIZE-1:0] imm8_zx;
    logic [WORD_SIZE-1:0] imm8_sx;
    logic [WORD_SIZE-1:0] imm12_zx;
    logic [WORD_SIZE-1:0] br_target;

    assign op_w     = instr_q[WORD_SIZE-1 -: OP_SIZE];
    assign rd_idx   = instr_q[8 +: RIDX_W];
    assign rs_idx   = instr_q[4 +: RIDX_W];
    assign rt_idx   = instr_q[0 +: RIDX_W];
    assign is_alu   = ~op_w[OP_SIZE-1];
    assign imm8_zx  = {{(WORD_SIZE-8){1'b0}}, instr_q[7:0]};
    assign imm8_sx  = {{(WORD_SIZE-8){instr_q[7]}}, instr_q[7:0]};
    assign imm12_zx = {{(WORD_SIZE-12){1'b0}}, instr_q[11:0]};
    // PC still holds the branch's own address during EXEC; wraps mod 2^16
    assign br_target = pc_counter + imm8_sx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            rd_val_q     <= '0;
            imem_req_q   <= 1'b0;
            alu_data_1_q <= '0;
            alu_data_2_q <= '0;
            alu_sel_q    <= '0;
            pc_data_q    <= '0;
            pc_load_q    <= 1'b0;
            pc_inc_q     <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            zero_flag_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            // PC pulses are single-cycle by construction: set on EXEC->WB only
            pc_load_q <= 1'b0;
            pc_inc_q  <= 1'b0;

            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q    <= imem_data;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    rd_val_q <= rf_q[rd_idx];
                    if (is_alu) begin
                        alu_data_1_q <= rf_q[rs_idx];
                        alu_data_2_q <= rf_q[rt_idx];
                        alu_sel_q    <= op_w;
                    end
                    state_q <= S_EXEC;
                end

                S_EXEC: begin
                    state_q <= S_WB;
                    if (is_alu) begin
                        if (rd_idx != '0) begin
                            rf_q[rd_idx] <= alu_out;
                        end
                        zero_flag_q <= alu_zero_flag;
                        pc_inc_q    <= 1'b1;
                    end else begin
                        case (op_w)
                            OP_LI: begin
                                if (rd_idx != '0) begin
                                    rf_q[rd_idx] <= imm8_zx;
                                end
                                pc_inc_q <= 1'b1;
                            end
                            OP_BEQZ: begin
                                if (rd_val_q == '0) begin
                                    pc_data_q <= br_target;
                                    pc_load_q <= 1'b1;
                                end else begin
                                    pc_inc_q <= 1'b1;
                                end
                            end
                            OP_JMP: begin
                                pc_data_q <= imm12_zx;
                                pc_load_q <= 1'b1;
                            end
                            OP_HALT: begin
                                state_q  <= S_HALT;
                                busy_q   <= 1'b0;
                                halted_q <= 1'b1;
                            end
                            default: begin
                                pc_inc_q <= 1'b1;
                            end
                        endcase
                    end
                end

                S_WB: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_req_q ? pc_counter : '0;
    assign alu_data_1 = alu_data_1_q;
    assign alu_data_2 = alu_data_2_q;
    assign alu_sel    = alu_sel_q;
    assign pc_data    = pc_data_q;
    assign pc_load    = pc_load_q;
    assign pc_inc     = pc_inc_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign zero_flag  = zero_flag_q;

endmodule
